serial_operand_loader: RTL and testbench
========================================

# serial_operand_loader

Parallel-to-serial operand front end for the bit-serial adder datapath. Accepts one pair of WIDTH-bit operands per valid/ready handshake and presents them to the serial adder stage LSB-first, one bit pair per clock. Sideband flags mark the first bit (carry clear) and last bit (result capture). Back-to-back operands stream with no bubble cycle.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  loader accepts operands this cycle.
- in_a  input  WIDTH  operand A, parallel.
- in_b  input  WIDTH  operand B, parallel.
- ser_hold  input  1  downstream stall; freezes all serial outputs and internal state.
- ser_valid  output  1  ser_a/ser_b carry a valid bit pair.
- ser_a  output  1  current bit of A, LSB-first.
- ser_b  output  1  current bit of B, LSB-first.
- ser_first  output  1  bit 0 of an operand; adder clears carry.
- ser_last  output  1  bit WIDTH-1 of an operand; adder captures sum and carry-out.
- busy  output  1  equals ser_valid; status only.

## Operation
- States: IDLE, SHIFT.
- IDLE: ser_valid=0, in_ready=1. On in_valid&&in_ready: load shift_a<=in_a, shift_b<=in_b, bit_cnt<=0, go to SHIFT.
- SHIFT, ser_hold=0: ser_a=shift_a[0], ser_b=shift_b[0]; each cycle shift both right by one, bit_cnt+1.
- ser_first = SHIFT && bit_cnt==0; ser_last = SHIFT && bit_cnt==WIDTH-1.
- in_ready = IDLE || (ser_last && !ser_hold).
- On ser_last with ser_hold=0: if in_valid, load new operands, bit_cnt<=0, stay in SHIFT (no bubble); else go to IDLE.
- ser_hold=1 in SHIFT: shift registers, bit_cnt, state and all ser_* outputs unchanged; in_ready=0. ser_hold in IDLE has no effect.
- in_a/in_b are sampled only on the accept edge; later changes are ignored.
- Reset asserted at any time: state<=IDLE, shift regs and bit_cnt<=0; the in-flight operand is discarded, no partial completion.

## Timing
- Reset values: in_ready=1, ser_valid=0, ser_a=0, ser_b=0, ser_first=0, ser_last=0, busy=0.
- Accept on edge E: bit k presented during cycle E+1+k (absent hold); ser_last in cycle E+WIDTH.
- Throughput: one operand per WIDTH cycles sustained.
- ser_a, ser_b, ser_valid, ser_first, ser_last driven from registers/state only, no combinational path from inputs.
- in_ready depends combinationally on ser_hold only (no path from in_valid).
- Each hold cycle extends the operand by exactly one cycle.

## Structure
- Shared package serial_pkg: state enum (IDLE, SHIFT), function or localparam for counter width $clog2(WIDTH).
- Sub-module piso_shift_reg (WIDTH, load, shift enable, parallel in, serial out), instantiated twice for A and B; controller and counter in top level.

## Test plan
- Reset: hold reset=0 three cycles, in_valid=1 -> in_ready=1, ser_valid=0, all ser_* 0; nothing accepted while reset=0.
- Single operand: in_a=1100, in_b=1101, WIDTH=4 -> ser_a 0,0,1,1 / ser_b 1,0,1,1 in cycles E+1..E+4; ser_first only at E+1, ser_last only at E+4; IDLE at E+5.
- Back-to-back: 1010/1010 then 0111/0001 with in_valid held -> 8 consecutive valid cycles, ser_first at cycles 1 and 5, ser_last at 4 and 8, no gap.
- Hold: ser_hold=1 for 2 cycles during bit 1 of 1100/1101 -> ser_a=0, ser_b=0 frozen 3 cycles, ser_last at E+6, in_ready=0 throughout.
- Hold on last bit with in_valid=1 -> new operand not accepted until hold drops; then accepted that cycle.
- Reset mid-operation: reset=0 during bit 2 -> next cycle ser_valid=0, in_ready=1; following operand 0001/0001 serializes correctly from bit 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the bit-serial operand loader: controller states and
// the bit-counter width helper.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // A 1-bit counter is still needed at the minimum width of 2.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register; emits the LSB and shifts right.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = par_in;
    end else if (shift_en) begin
      data_d = {1'b0, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign ser_out = data_q[0];

endmodule

// File: rtl/serial_operand_loader.sv
// Operand front end for the bit-serial adder: accepts a parallel A/B pair
// and streams it LSB-first with first/last sideband flags.
//
// state | meaning
// IDLE  | no operand in flight, ready for a new pair
// SHIFT | presenting bit cnt_q of the loaded pair
module serial_operand_loader
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             ser_hold,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          in_shift;
  logic          at_last;
  logic          load;
  logic          shift_en;
  logic          bit_a;
  logic          bit_b;

  assign in_shift = (state_q == SHIFT);
  assign at_last  = in_shift && (cnt_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A stall freezes everything, including the handshake.
        if (!ser_hold) begin
          shift_en = 1'b1;
          if (at_last) begin
            in_ready = 1'b1;
            cnt_d    = '0;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
    .clk      (clk),
    .rst_n    (reset),
    .load     (load),
    .shift_en (shift_en),
    .par_in   (in_a),
    .ser_out  (bit_a)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
    .clk      (clk),
    .rst_n    (reset),
    .load     (load),
    .shift_en (shift_en),
    .par_in   (in_b),
    .ser_out  (bit_b)
  );

  assign ser_valid = in_shift;
  assign busy      = in_shift;
  assign ser_a     = in_shift & bit_a;
  assign ser_b     = in_shift & bit_b;
  assign ser_first = in_shift && (cnt_q == '0);
  assign ser_last  = at_last;

endmodule

// File: tb/tb_serial_operand_loader.sv
// Self-checking bench for serial_operand_loader: directed scenarios plus a
// randomized run against a queue-of-bits reference model.
module tb_serial_operand_loader;

  localparam int WIDTH = 4;
  // {ser_valid, ser_a, ser_b, ser_first, ser_last, in_ready, busy}
  localparam logic [6:0] IDLE_V = 7'b0000010;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             ser_hold = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last, busy;
  logic [6:0]       obs;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit a;
    bit b;
    bit f;
    bit l;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  serial_operand_loader #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_hold  (ser_hold),
    .ser_valid (ser_valid),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy)
  );

  assign obs = {ser_valid, ser_a, ser_b, ser_first, ser_last, in_ready, busy};

  // Expected output vector while bit k of (a,b) is on the serial lines.
  function automatic logic [6:0] exp_bit(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input int k, input logic hold);
    logic lst;
    lst = (k == WIDTH - 1);
    return {1'b1, a[k], b[k], (k == 0), lst, lst && !hold, 1'b1};
  endfunction

  // Drive point for the next cycle: just after the rising edge.
  task automatic wait_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_a     = 4'b1111;
    in_b     = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wait_cyc();
      #1;
      checks++;
      if (obs !== IDLE_V) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, obs, IDLE_V);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    wait_cyc();
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = 4'b1100;
    b = 4'b1101;
    wait_cyc();
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    ser_hold = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL single_pre got=%b exp=%b", obs, IDLE_V);
    end
    for (int k = 0; k < WIDTH; k++) begin
      wait_cyc();
      if (k == 0) begin
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
      end
      #1;
      checks++;
      if (obs !== exp_bit(a, b, k, 1'b0)) begin
        failures++;
        $display("FAIL single_bit k=%0d got=%b exp=%b", k, obs, exp_bit(a, b, k, 1'b0));
      end
    end
    wait_cyc();
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL single_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [6:0]       e;
    a0 = 4'b1010; b0 = 4'b1010;
    a1 = 4'b0111; b1 = 4'b0001;
    wait_cyc();
    in_valid = 1'b1;
    in_a     = a0;
    in_b     = b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      wait_cyc();
      if (i == 0) begin
        in_a = a1;
        in_b = b1;
      end
      if (i == WIDTH) begin
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
      end
      #1;
      e = (i < WIDTH) ? exp_bit(a0, b0, i, 1'b0) : exp_bit(a1, b1, i - WIDTH, 1'b0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL b2b_bit cyc=%0d got=%b exp=%b", i + 1, obs, e);
      end
    end
    wait_cyc();
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] a, b;
    logic [6:0]       e;
    int hp[6] = '{0, 1, 1, 0, 0, 0};
    int bi[6] = '{0, 1, 1, 1, 2, 3};
    a = 4'b1100;
    b = 4'b1101;
    wait_cyc();
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int c = 0; c < 6; c++) begin
      wait_cyc();
      in_valid = 1'b0;
      ser_hold = (hp[c] != 0);
      #1;
      e = exp_bit(a, b, bi[c], hp[c] != 0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL hold_bit cyc=%0d got=%b exp=%b", c + 1, obs, e);
      end
    end
    wait_cyc();
    ser_hold = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL hold_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_hold_last();
    logic [WIDTH-1:0] a1, b1, a2, b2;
    logic [6:0]       e;
    a1 = WIDTH'($urandom); b1 = WIDTH'($urandom);
    a2 = WIDTH'($urandom); b2 = WIDTH'($urandom);
    wait_cyc();
    in_valid = 1'b1;
    in_a     = a1;
    in_b     = b1;
    for (int c = 0; c < 10; c++) begin
      wait_cyc();
      in_valid = (c >= 3 && c <= 5);
      ser_hold = (c == 3 || c == 4);
      if (c == 3) begin
        in_a = a2;
        in_b = b2;
      end
      #1;
      if (c < 3)      e = exp_bit(a1, b1, c, 1'b0);
      else if (c < 6) e = exp_bit(a1, b1, WIDTH - 1, ser_hold);
      else            e = exp_bit(a2, b2, c - 6, 1'b0);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL hold_last cyc=%0d got=%b exp=%b", c + 1, obs, e);
      end
    end
    wait_cyc();
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL hold_last_idle got=%b exp=%b", obs, IDLE_V);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] a, b;
    a = 4'b1011;
    b = 4'b0110;
    wait_cyc();
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 3; k++) begin
      wait_cyc();
      in_valid = 1'b0;
      #1;
      checks++;
      if (obs !== exp_bit(a, b, k, 1'b0)) begin
        failures++;
        $display("FAIL rmid_bit k=%0d got=%b exp=%b", k, obs, exp_bit(a, b, k, 1'b0));
      end
    end
    rst_n = 1'b0;
    wait_cyc();
    #1;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL rmid_flush got=%b exp=%b", obs, IDLE_V);
    end
    rst_n = 1'b1;
    a = 4'b0001;
    b = 4'b0001;
    wait_cyc();
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < WIDTH; k++) begin
      wait_cyc();
      in_valid = 1'b0;
      #1;
      checks++;
      if (obs !== exp_bit(a, b, k, 1'b0)) begin
        failures++;
        $display("FAIL rmid_next k=%0d got=%b exp=%b", k, obs, exp_bit(a, b, k, 1'b0));
      end
    end
    wait_cyc();
    #1;
  endtask

  // Reference: a queue of bit pairs still owed to the adder.
  task automatic test_random();
    logic       exp_ready;
    logic [6:0] e;
    ent_t       t;
    q.delete();
    for (int n = 0; n < 400; n++) begin
      wait_cyc();
      in_valid = ($urandom_range(0, 9) < 6);
      ser_hold = ($urandom_range(0, 9) < 2);
      in_a     = WIDTH'($urandom);
      in_b     = WIDTH'($urandom);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && !ser_hold);
      checks++;
      if (q.size() > 0) begin
        e = {1'b1, q[0].a, q[0].b, q[0].f, q[0].l, exp_ready, 1'b1};
        if (obs !== e) begin
          failures++;
          $display("FAIL rand_busy n=%0d got=%b exp=%b", n, obs, e);
        end
      end else begin
        if ({ser_valid, ser_first, ser_last, in_ready, busy} !== 5'b00010) begin
          failures++;
          $display("FAIL rand_idle n=%0d got=%b exp=%b", n, obs, IDLE_V);
        end
      end
      if (q.size() > 0 && !ser_hold) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        for (int k = 0; k < WIDTH; k++) begin
          t.a = in_a[k];
          t.b = in_b[k];
          t.f = (k == 0);
          t.l = (k == WIDTH - 1);
          q.push_back(t);
        end
      end
    end
    ser_hold = 1'b0;
    in_valid = 1'b0;
    begin
      int budget;
      budget = 0;
      while (ser_valid === 1'b1 && budget < 2 * WIDTH) begin
        wait_cyc();
        #1;
        budget++;
      end
      checks++;
      if (ser_valid !== 1'b0) begin
        failures++;
        $display("FAIL rand_drain got=%b exp=%b", ser_valid, 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_hold_last();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
